// File: rtl/fpu_pkg.sv
// Shared FP32 field constants and the per-word class bundle
// used by the multiplier/adder result stages.
package fpu_pkg;

  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam int MAN_W   = 23;

  localparam logic [7:0]  EXP_ALL1 = 8'hFF;
  localparam logic [31:0] QNAN     = 32'h7FC00000;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic denorm;
  } fp32_class_t;

  typedef struct packed {
    logic [31:0] result;
    fp32_class_t cls;
  } q_entry_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational FP32 classifier.
// Ports: word (32b FP32 in) -> cls {nan,inf,zero,denorm}; normal = 0.
module fp32_classify
  import fpu_pkg::*;
(
  input  logic [31:0]  word,
  output fp32_class_t  cls
);

  logic [7:0]       exp_f;
  logic [MAN_W-1:0] man_f;
  logic             unused_sign;
  logic             exp_one;
  logic             exp_zero;
  logic             man_zero;

  assign exp_f       = word[EXP_MSB:EXP_LSB];
  assign man_f       = word[MAN_W-1:0];
  assign unused_sign = word[31];

  assign exp_one  = (exp_f == EXP_ALL1);
  assign exp_zero = (exp_f == 8'h00);
  assign man_zero = (man_f == '0);

  assign cls.nan    = exp_one  & ~man_zero;
  assign cls.inf    = exp_one  &  man_zero;
  assign cls.zero   = exp_zero &  man_zero;
  assign cls.denorm = exp_zero & ~man_zero;

endmodule

// File: rtl/fpu_mult_result_queue.sv
// Show-ahead result FIFO behind the FP32 multiplier, with per-word
// class tags, sticky class flags and a saturating push counter.
module fpu_mult_result_queue
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [3:0]               out_class,
  output logic [$clog2(DEPTH):0]   level,
  output logic [3:0]               sticky_flags,
  output logic [CNT_W-1:0]         result_count,
  input  logic                     clr_stats
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  q_entry_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [LW-1:0]   lvl_q;
  logic [3:0]      flags_q;
  logic [CNT_W-1:0] cnt_q;

  fp32_class_t     in_cls;
  logic            push;
  logic            pop;
  logic [3:0]      flags_base;
  logic [CNT_W-1:0] cnt_base;

  fp32_classify u_classify (
    .word (in_result),
    .cls  (in_cls)
  );

  // Readiness depends on registered level only, so a full queue
  // refuses a push even when the head is popped in the same cycle.
  assign in_ready  = (lvl_q != LW'(DEPTH));
  assign out_valid = (lvl_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_result   = mem[rd_ptr].result;
  assign out_class    = mem[rd_ptr].cls;
  assign level        = lvl_q;
  assign sticky_flags = flags_q;
  assign result_count = cnt_q;

  // Clear takes effect before the same-cycle push accumulates.
  assign flags_base = clr_stats ? 4'b0000 : flags_q;
  assign cnt_base   = clr_stats ? '0 : cnt_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{result: in_result, cls: in_cls};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      lvl_q   <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      unique case ({push, pop})
        2'b10:   lvl_q <= lvl_q + 1'b1;
        2'b01:   lvl_q <= lvl_q - 1'b1;
        default: lvl_q <= lvl_q;
      endcase

      if (push) begin
        flags_q <= flags_base | in_cls;
        cnt_q   <= (&cnt_base) ? cnt_base : cnt_base + 1'b1;
      end else begin
        flags_q <= flags_base;
        cnt_q   <= cnt_base;
      end
    end
  end

endmodule

// File: tb/tb_fpu_mult_result_queue.sv
// Directed bench for fpu_mult_result_queue (DEPTH=4) plus a
// CNT_W=2 instance sharing the stimulus to exercise saturation.
module tb_fpu_mult_result_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_class;
  logic [2:0]  level;
  logic [3:0]  sticky_flags;
  logic [15:0] result_count;
  logic        clr_stats;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [31:0] s_out_result;
  logic [3:0]  s_out_class;
  logic [2:0]  s_level;
  logic [3:0]  s_flags;
  logic [1:0]  s_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fpu_mult_result_queue #(.DEPTH(4), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_class    (out_class),
    .level        (level),
    .sticky_flags (sticky_flags),
    .result_count (result_count),
    .clr_stats    (clr_stats)
  );

  fpu_mult_result_queue #(.DEPTH(4), .CNT_W(2)) dut_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (s_in_ready),
    .in_result    (in_result),
    .out_valid    (s_out_valid),
    .out_ready    (out_ready),
    .out_result   (s_out_result),
    .out_class    (s_out_class),
    .level        (s_level),
    .sticky_flags (s_flags),
    .result_count (s_count),
    .clr_stats    (clr_stats)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_result = '0;
    out_ready = 1'b0;
    clr_stats = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_flags", 32'(sticky_flags), 32'd0);
    chk("rst_count", 32'(result_count), 32'd0);

    // 1: single push, 1-cycle latency
    in_valid = 1'b1; in_result = 32'h40C00000;
    step();
    in_valid = 1'b0;
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_result", out_result, 32'h40C00000);
    chk("t1_class", 32'(out_class), 32'h0);
    chk("t1_level", 32'(level), 32'd1);
    chk("t1_count", 32'(result_count), 32'd1);

    // 2: pop + clear, then one word of each class
    out_ready = 1'b1; clr_stats = 1'b1;
    step();
    out_ready = 1'b0; clr_stats = 1'b0;
    chk("t2_clr_count", 32'(result_count), 32'd0);
    chk("t2_level0", 32'(level), 32'd0);
    in_valid = 1'b1;
    in_result = 32'h7FC00000; step();
    in_result = 32'hFF800000; step();
    in_result = 32'h80000000; step();
    in_result = 32'h00000001; step();
    in_valid = 1'b0;
    chk("t2_level", 32'(level), 32'd4);
    chk("t2_in_ready", 32'(in_ready), 32'd0);
    chk("t2_flags", 32'(sticky_flags), 32'hF);
    chk("t2_count", 32'(result_count), 32'd4);
    out_ready = 1'b1;
    chk("t2_c0", 32'(out_class), 32'b1000);
    chk("t2_d0", out_result, 32'h7FC00000); step();
    chk("t2_c1", 32'(out_class), 32'b0100);
    chk("t2_d1", out_result, 32'hFF800000); step();
    chk("t2_c2", 32'(out_class), 32'b0010);
    chk("t2_d2", out_result, 32'h80000000); step();
    chk("t2_c3", 32'(out_class), 32'b0001);
    chk("t2_d3", out_result, 32'h00000001); step();
    out_ready = 1'b0;
    chk("t2_empty", 32'(out_valid), 32'd0);

    // 3: overfill with 6 pushes
    clr_stats = 1'b1; step(); clr_stats = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_result = 32'h3F800000 + 32'(i);
      step();
      if (i == 3) chk("t3_full_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    chk("t3_level", 32'(level), 32'd4);
    chk("t3_count", 32'(result_count), 32'd4);
    // head must hold while out_ready=0
    step();
    chk("t3_hold", out_result, 32'h3F800000);
    out_ready = 1'b1;
    chk("t3_p0", out_result, 32'h3F800000); step();
    chk("t3_p1", out_result, 32'h3F800001); step();
    chk("t3_p2", out_result, 32'h3F800002); step();
    chk("t3_p3", out_result, 32'h3F800003); step();
    out_ready = 1'b0;
    chk("t3_level0", 32'(level), 32'd0);

    // 4: push+pop at level 1, then push refused when full
    in_valid = 1'b1; in_result = 32'h41000001; step();
    in_result = 32'h41000002; out_ready = 1'b1; step();
    out_ready = 1'b0;
    chk("t4_level1", 32'(level), 32'd1);
    chk("t4_head", out_result, 32'h41000002);
    in_result = 32'h41000003; step();
    in_result = 32'h41000004; step();
    in_result = 32'h41000005; step();
    chk("t4_level4", 32'(level), 32'd4);
    in_result = 32'h41000006; out_ready = 1'b1; step();
    chk("t4_level3", 32'(level), 32'd3);
    chk("t4_head3", out_result, 32'h41000003);
    chk("t4_in_ready", 32'(in_ready), 32'd1);

    // 5: clear together with push, then clear alone
    out_ready = 1'b0; clr_stats = 1'b1; in_result = 32'h7F800000;
    step();
    in_valid = 1'b0;
    chk("t5_flags", 32'(sticky_flags), 32'b0100);
    chk("t5_count", 32'(result_count), 32'd1);
    chk("t5_level", 32'(level), 32'd4);
    out_ready = 1'b1;
    step();
    clr_stats = 1'b0; out_ready = 1'b0;
    chk("t5_clr_flags", 32'(sticky_flags), 32'd0);
    chk("t5_clr_count", 32'(result_count), 32'd0);
    chk("t5_level3", 32'(level), 32'd3);

    // 6: reset mid-stream
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_flags", 32'(sticky_flags), 32'd0);
    chk("t6_count", 32'(result_count), 32'd0);
    in_valid = 1'b1; in_result = 32'h80400000; step();
    in_valid = 1'b0;
    chk("t6_level1", 32'(level), 32'd1);
    chk("t6_head", out_result, 32'h80400000);
    chk("t6_class", 32'(out_class), 32'b0001);
    chk("t6_flags1", 32'(sticky_flags), 32'b0001);

    // saturation: 5 more pushes through a flowing queue
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_result = 32'h3F000000 + 32'(i);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("sat_count16", 32'(result_count), 32'd6);
    chk("sat_count2", 32'(s_count), 32'd3);
    chk("sat_level", 32'(level), 32'd1);
    chk("sat_head", out_result, 32'h3F000004);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
